riscvsoc_bus_arbiter: RTL and testbench
=======================================

# riscvsoc_bus_arbiter

Round-robin arbiter that shares the SoC's single memory/peripheral slave port between up to NM bus masters: instruction fetch, data load/store, and the debug/loader port. It sits between the core-side master ports and the system bus inside `riscvsoc`. It serialises transactions one at a time, latches the winning master's request, and drives the slave handshake. It returns read data and an error flag, and aborts any transaction the slave fails to acknowledge within a bounded time.

## Interface
- NM, 3: number of masters, 2..8.
- AW, 32: address width.
- DW, 32: data width; strobe width is DW/8.
- TIMEOUT, 255: maximum BUSY cycles waiting for `s_ack`; 0 disables the timeout.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_req  in  NM  per-master request level.
- m_we  in  NM  per-master write enable.
- m_addr  in  NM*AW  flattened addresses; master i occupies bits [i*AW +: AW].
- m_wdata  in  NM*DW  flattened write data.
- m_wstrb  in  NM*DW/8  flattened byte strobes.
- m_ack  out  NM  one-cycle completion pulse to the granted master.
- m_err  out  1  high with `m_ack` when the transaction timed out.
- m_rdata  out  DW  read data, valid while `m_ack` is high.
- s_req  out  1  slave request.
- s_we, s_addr, s_wdata, s_wstrb  out  1/AW/DW/DW/8  latched payload of the granted master.
- s_ack  in  1  slave completion; read data is valid in the same cycle.
- s_rdata  in  DW  slave read data.
- busy  out  1  high in BUSY or DONE.
- grant_id  out  3  index of the current or last granted master.

## Operation
- FSM has three states: IDLE, BUSY and DONE. Reset puts it in IDLE.
- **IDLE.** If any `m_req` bit is set:
  - Choose the winner by round-robin search starting at `last+1` modulo NM.
  - Latch the winner's `we`, `addr`, `wdata` and `wstrb` into the `s_*` registers.
  - Set `grant_id` and `last` to the winner, clear the timeout counter, and go to BUSY.
- **BUSY.** `s_req` is 1 and the payload is held constant.
  - `s_ack`=1: register `m_rdata` from `s_rdata` (the capture happens on writes too), set `m_err`=0, go to DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT (and TIMEOUT≠0): set `m_err`=1, set `m_rdata`=32'hDEADBEEF truncated/extended to DW, go to DONE.
  - If `s_ack` and the timeout limit occur in the same cycle, the ack wins and `m_err`=0.
- **DONE.** `s_req` is 0. `m_ack[grant_id]` is 1 for exactly this cycle. The next state is always IDLE.
- **Master contract.** A master holds `m_req` and its payload until it sees `m_ack`. It deasserts `m_req` in the `m_ack` cycle or starts a new request.
  - A master that drops `m_req` during BUSY still has its transaction completed and acked. Requests are never cancelled.
- **Fairness.** Each master that holds its request is granted within NM transactions.
- `last` resets to NM-1, so master 0 wins the first contention.
- **Reset values.** All outputs are 0, including `m_rdata`, the `s_*` payload, `grant_id` and `busy`. Assertion of `rst_n` mid-transaction clears the FSM and `s_req` immediately (asynchronously), and no `m_ack` is issued.

## Timing
- `m_req` sampled high in IDLE at edge N gives `s_req`=1 and a stable payload from N+1.
- `s_ack` sampled at edge K (first possible K = N+1) gives `m_ack`/`m_rdata` during the cycle after K, then IDLE.
- Minimum transaction is 3 cycles from grant to the next IDLE arbitration. Back-to-back throughput is one transaction per 3 cycles with a zero-wait slave.
- On timeout, `m_ack` with `m_err` occurs TIMEOUT+1 cycles after `s_req` rises.
- `s_ack` outside BUSY is ignored.
- `m_req` changes are only sampled in IDLE.

## Test plan
- **Single read, master 1.**
  - Stimulus: addr=0x0000_1000, slave acks 2 cycles after `s_req` with 0xCAFEBABE.
  - Required: `s_addr`=0x1000, `s_we`=0, `m_ack`=3'b010 for one cycle, `m_rdata`=0xCAFEBABE, `m_err`=0.
- **All three masters request continuously from reset.**
  - Stimulus: zero-wait slave.
  - Required: grant order 0,1,2,0,1,2; one `m_ack` per 3 cycles.
- **Write by master 2.**
  - Stimulus: wdata=0x12345678, wstrb=4'b0011.
  - Required: `s_we`=1, `s_wdata`/`s_wstrb` match and are held stable across a 5-cycle slave wait.
- **Timeout.**
  - Stimulus: TIMEOUT=4, slave never acks.
  - Required: `s_req` high for 5 cycles, then `m_ack` with `m_err`=1 and `m_rdata`=0xDEADBEEF. The next request then proceeds normally.
- **Ack on the timeout cycle.**
  - Stimulus: `s_ack` coincides with counter=TIMEOUT.
  - Required: `m_err`=0 and `m_rdata`=`s_rdata`.
- **Reset mid-BUSY.**
  - Stimulus: `rst_n` low for 1 cycle during a wait.
  - Required: `s_req`, `busy` and `m_ack` go to 0 immediately with no ack. After reset, master 0 has priority.

Source files
------------

// File: rtl/riscvsoc_bus_arbiter_if.sv
// Bundle of the arbiter's master-facing and slave-facing bus signals.
// The "master" modport is the arbiter's view (it masters the system bus); "slave" is the environment's view.
interface riscvsoc_bus_arbiter_if #(
    parameter int NM = 3,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [NM-1:0]        m_req;
    logic [NM-1:0]        m_we;
    logic [NM*AW-1:0]     m_addr;
    logic [NM*DW-1:0]     m_wdata;
    logic [NM*DW/8-1:0]   m_wstrb;
    logic [NM-1:0]        m_ack;
    logic                 m_err;
    logic [DW-1:0]        m_rdata;
    logic                 s_req;
    logic                 s_we;
    logic [AW-1:0]        s_addr;
    logic [DW-1:0]        s_wdata;
    logic [DW/8-1:0]      s_wstrb;
    logic                 s_ack;
    logic [DW-1:0]        s_rdata;
    logic                 busy;
    logic [2:0]           grant_id;

    modport master (
        input  m_req, m_we, m_addr, m_wdata, m_wstrb, s_ack, s_rdata,
        output m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, s_wstrb,
               busy, grant_id
    );

    modport slave (
        output m_req, m_we, m_addr, m_wdata, m_wstrb, s_ack, s_rdata,
        input  m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, s_wstrb,
               busy, grant_id
    );
endinterface

// File: rtl/riscvsoc_bus_arbiter.sv
// Round-robin arbiter serialising NM bus masters onto one slave port,
// with a bounded wait for the slave acknowledge.
module riscvsoc_bus_arbiter #(
    parameter int NM      = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    riscvsoc_bus_arbiter_if.master bus
);
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_last;
    logic [2:0]      r_grant;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_wstrb;
    logic [DW-1:0]   r_rdata;
    logic            r_err;

    // Per-master views padded to 8 entries so a 3-bit index is always exact.
    logic [7:0]      w_req_pad;
    logic [7:0]      w_we_pad;
    logic [AW-1:0]   w_addr_pad  [8];
    logic [DW-1:0]   w_wdata_pad [8];
    logic [SW-1:0]   w_wstrb_pad [8];

    logic            w_found;
    logic [2:0]      w_winner;
    logic [3:0]      w_sum;
    logic            w_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < NM) begin : g_real
                assign w_req_pad[gi]   = bus.m_req[gi];
                assign w_we_pad[gi]    = bus.m_we[gi];
                assign w_addr_pad[gi]  = bus.m_addr[gi*AW +: AW];
                assign w_wdata_pad[gi] = bus.m_wdata[gi*DW +: DW];
                assign w_wstrb_pad[gi] = bus.m_wstrb[gi*SW +: SW];
            end else begin : g_pad
                assign w_req_pad[gi]   = 1'b0;
                assign w_we_pad[gi]    = 1'b0;
                assign w_addr_pad[gi]  = '0;
                assign w_wdata_pad[gi] = '0;
                assign w_wstrb_pad[gi] = '0;
            end
        end
    endgenerate

    // Search last+1 .. last+NM (mod NM); the first requester found wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 1; k <= NM; k++) begin
            w_sum = {1'b0, r_last} + 4'(k);
            if (w_sum >= 4'(NM)) begin
                w_sum = w_sum - 4'(NM);
            end
            if (!w_found && w_req_pad[w_sum[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[2:0];
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_state_next = ST_BUSY;
            ST_BUSY: if (bus.s_ack || w_timeout) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 3'(NM - 1);
            r_grant <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_we    <= w_we_pad[w_winner];
                        r_addr  <= w_addr_pad[w_winner];
                        r_wdata <= w_wdata_pad[w_winner];
                        r_wstrb <= w_wstrb_pad[w_winner];
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                        r_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    // An ack arriving on the limit cycle still counts as success.
                    if (bus.s_ack) begin
                        r_rdata <= bus.s_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_req    = (r_state == ST_BUSY);
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.s_we     = r_we;
    assign bus.s_addr   = r_addr;
    assign bus.s_wdata  = r_wdata;
    assign bus.s_wstrb  = r_wstrb;
    assign bus.m_rdata  = r_rdata;
    assign bus.m_err    = r_err && (r_state == ST_DONE);
    assign bus.grant_id = r_grant;

    generate
        for (gi = 0; gi < NM; gi++) begin : g_ack
            assign bus.m_ack[gi] = (r_state == ST_DONE) && (r_grant == 3'(gi));
        end
    endgenerate
endmodule

// File: tb/tb_riscvsoc_bus_arbiter.sv
// Directed bench for riscvsoc_bus_arbiter: one long-timeout instance and one TIMEOUT=4 instance.
module tb_riscvsoc_bus_arbiter;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    riscvsoc_bus_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bif ();
    riscvsoc_bus_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) tif ();

    riscvsoc_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif)
    );
    riscvsoc_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .bus(tif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bif.s_req !== 1'b0) begin errors++; $display("FAIL reset_s_req got %b want 0", bif.s_req); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bif.busy); end
        checks++; if (bif.m_ack !== 3'b000) begin errors++; $display("FAIL reset_m_ack got %b want 000", bif.m_ack); end
        checks++; if (bif.grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", bif.grant_id); end
        checks++; if (bif.m_rdata !== 32'h0) begin errors++; $display("FAIL reset_m_rdata got %h want 0", bif.m_rdata); end
        checks++; if ({bif.s_we, bif.s_addr, bif.s_wdata, bif.s_wstrb, bif.m_err} !== '0) begin
            errors++; $display("FAIL reset_payload got %h/%h/%h want 0", bif.s_addr, bif.s_wdata, bif.s_wstrb); end
        checks++; if (tif.busy !== 1'b0) begin errors++; $display("FAIL reset_t_busy got %b want 0", tif.busy); end
        rst_n = 1'b1;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        for (int i = 0; i < NM; i++) bif.m_addr[i*AW +: AW] = 32'h100 * (i + 1);
        bif.m_req = 3'b111;
        bif.s_ack = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp = 3'(t % 3);
            bif.s_rdata = 32'hA000_0000 + t;
            tick();
            checks++; if (bif.s_req !== 1'b1 || bif.grant_id !== exp) begin
                errors++; $display("FAIL rr_grant t=%0d got req=%b id=%0d want req=1 id=%0d", t, bif.s_req, bif.grant_id, exp); end
            checks++; if (bif.s_addr !== 32'h100 * (exp + 1)) begin
                errors++; $display("FAIL rr_addr t=%0d got %h want %h", t, bif.s_addr, 32'h100 * (exp + 1)); end
            tick();
            checks++; if (bif.m_ack !== 3'(1 << exp) || bif.m_rdata !== 32'hA000_0000 + t) begin
                errors++; $display("FAIL rr_ack t=%0d got ack=%b rdata=%h want ack=%b rdata=%h", t, bif.m_ack, bif.m_rdata, 3'(1 << exp), 32'hA000_0000 + t); end
            $display("txn rr t=%0d grant=%0d ack=%b rdata=%h", t, bif.grant_id, bif.m_ack, bif.m_rdata);
            tick();
            checks++; if (bif.m_ack !== 3'b000 || bif.busy !== 1'b0) begin
                errors++; $display("FAIL rr_idle t=%0d got ack=%b busy=%b want 000/0", t, bif.m_ack, bif.busy); end
        end
        bif.m_req = 3'b000;
        bif.s_ack = 1'b0;
    endtask

    task automatic test_single_read();
        bif.m_addr[1*AW +: AW] = 32'h0000_1000;
        bif.m_we[1] = 1'b0;
        bif.m_req = 3'b010;
        tick();
        checks++; if (bif.s_req !== 1'b1 || bif.s_addr !== 32'h1000 || bif.s_we !== 1'b0) begin
            errors++; $display("FAIL rd_req got req=%b addr=%h we=%b want 1/00001000/0", bif.s_req, bif.s_addr, bif.s_we); end
        tick();
        checks++; if (bif.m_ack !== 3'b000 || bif.s_req !== 1'b1) begin
            errors++; $display("FAIL rd_wait got ack=%b req=%b want 000/1", bif.m_ack, bif.s_req); end
        tick();
        bif.s_ack = 1'b1;
        bif.s_rdata = 32'hCAFEBABE;
        tick();
        checks++; if (bif.m_ack !== 3'b010 || bif.m_rdata !== 32'hCAFEBABE || bif.m_err !== 1'b0) begin
            errors++; $display("FAIL rd_ack got ack=%b rdata=%h err=%b want 010/cafebabe/0", bif.m_ack, bif.m_rdata, bif.m_err); end
        $display("txn read m1 addr=%h rdata=%h", bif.s_addr, bif.m_rdata);
        bif.m_req = 3'b000;
        bif.s_ack = 1'b0;
        tick();
        checks++; if (bif.m_ack !== 3'b000 || bif.s_req !== 1'b0) begin
            errors++; $display("FAIL rd_after got ack=%b req=%b want 000/0", bif.m_ack, bif.s_req); end
    endtask

    task automatic test_write();
        bif.m_we[2] = 1'b1;
        bif.m_addr[2*AW +: AW] = 32'h0000_2004;
        bif.m_wdata[2*DW +: DW] = 32'h12345678;
        bif.m_wstrb[2*SW +: SW] = 4'b0011;
        bif.m_req = 3'b100;
        tick();
        // Master inputs change under the transaction; the latched payload must not.
        bif.m_req = 3'b000;
        bif.m_wdata[2*DW +: DW] = 32'hFFFF_FFFF;
        bif.m_wstrb[2*SW +: SW] = 4'b1111;
        bif.m_we[2] = 1'b0;
        for (int w = 0; w < 5; w++) begin
            checks++; if ({bif.s_req, bif.s_we, bif.s_wdata, bif.s_wstrb} !== {1'b1, 1'b1, 32'h12345678, 4'b0011}) begin
                errors++; $display("FAIL wr_hold w=%0d got req=%b we=%b wdata=%h wstrb=%b want 1/1/12345678/0011", w, bif.s_req, bif.s_we, bif.s_wdata, bif.s_wstrb); end
            tick();
        end
        bif.s_ack = 1'b1;
        bif.s_rdata = 32'h0000_55AA;
        tick();
        checks++; if (bif.m_ack !== 3'b100 || bif.m_rdata !== 32'h0000_55AA || bif.m_err !== 1'b0) begin
            errors++; $display("FAIL wr_ack got ack=%b rdata=%h err=%b want 100/000055aa/0", bif.m_ack, bif.m_rdata, bif.m_err); end
        $display("txn write m2 wdata=%h wstrb=%b ack=%b", bif.s_wdata, bif.s_wstrb, bif.m_ack);
        bif.s_ack = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        tif.m_addr[0 +: AW] = 32'h0000_3000;
        tif.m_req = 3'b001;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if (tif.s_req !== 1'b1 || tif.m_ack !== 3'b000) begin
                errors++; $display("FAIL to_wait c=%0d got req=%b ack=%b want 1/000", c, tif.s_req, tif.m_ack); end
            tick();
        end
        checks++; if (tif.m_ack !== 3'b001 || tif.m_err !== 1'b1 || tif.m_rdata !== 32'hDEADBEEF || tif.s_req !== 1'b0) begin
            errors++; $display("FAIL to_ack got ack=%b err=%b rdata=%h req=%b want 001/1/deadbeef/0", tif.m_ack, tif.m_err, tif.m_rdata, tif.s_req); end
        $display("txn timeout m0 ack=%b err=%b rdata=%h", tif.m_ack, tif.m_err, tif.m_rdata);
        tif.m_req = 3'b000;
        tick();
        tif.m_req = 3'b010;
        tick();
        checks++; if (tif.grant_id !== 3'd1 || tif.s_req !== 1'b1) begin
            errors++; $display("FAIL to_next_grant got id=%0d req=%b want 1/1", tif.grant_id, tif.s_req); end
        tif.s_ack = 1'b1;
        tif.s_rdata = 32'h1111_2222;
        tick();
        checks++; if (tif.m_ack !== 3'b010 || tif.m_err !== 1'b0 || tif.m_rdata !== 32'h1111_2222) begin
            errors++; $display("FAIL to_next_ack got ack=%b err=%b rdata=%h want 010/0/11112222", tif.m_ack, tif.m_err, tif.m_rdata); end
        $display("txn after-timeout m1 ack=%b err=%b rdata=%h", tif.m_ack, tif.m_err, tif.m_rdata);
        tif.m_req = 3'b000;
        tif.s_ack = 1'b0;
        tick();
    endtask

    task automatic test_ack_on_timeout();
        tif.m_req = 3'b100;
        tick();
        for (int c = 0; c < 4; c++) tick();
        checks++; if (tif.s_req !== 1'b1) begin
            errors++; $display("FAIL edge_busy got req=%b want 1", tif.s_req); end
        tif.s_ack = 1'b1;
        tif.s_rdata = 32'h0BAD_F00D;
        tick();
        checks++; if (tif.m_ack !== 3'b100 || tif.m_err !== 1'b0 || tif.m_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL edge_ack got ack=%b err=%b rdata=%h want 100/0/0badf00d", tif.m_ack, tif.m_err, tif.m_rdata); end
        $display("txn ack-on-limit m2 ack=%b err=%b rdata=%h", tif.m_ack, tif.m_err, tif.m_rdata);
        tif.m_req = 3'b000;
        tif.s_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bif.m_req = 3'b010;
        tick();
        tick();
        checks++; if (bif.s_req !== 1'b1 || bif.grant_id !== 3'd1) begin
            errors++; $display("FAIL mid_pre got req=%b id=%0d want 1/1", bif.s_req, bif.grant_id); end
        rst_n = 1'b0;
        #1;
        checks++; if (bif.s_req !== 1'b0 || bif.busy !== 1'b0 || bif.m_ack !== 3'b000 || bif.grant_id !== 3'd0) begin
            errors++; $display("FAIL mid_async got req=%b busy=%b ack=%b id=%0d want 0/0/000/0", bif.s_req, bif.busy, bif.m_ack, bif.grant_id); end
        tick();
        checks++; if (bif.m_ack !== 3'b000 || bif.s_req !== 1'b0) begin
            errors++; $display("FAIL mid_hold got ack=%b req=%b want 000/0", bif.m_ack, bif.s_req); end
        rst_n = 1'b1;
        bif.m_req = 3'b111;
        bif.s_ack = 1'b1;
        bif.s_rdata = 32'h7777_0000;
        tick();
        checks++; if (bif.grant_id !== 3'd0 || bif.s_req !== 1'b1) begin
            errors++; $display("FAIL mid_prio got id=%0d req=%b want 0/1", bif.grant_id, bif.s_req); end
        tick();
        checks++; if (bif.m_ack !== 3'b001 || bif.m_rdata !== 32'h7777_0000) begin
            errors++; $display("FAIL mid_ack got ack=%b rdata=%h want 001/77770000", bif.m_ack, bif.m_rdata); end
        $display("txn post-reset grant=%0d ack=%b", bif.grant_id, bif.m_ack);
        bif.m_req = 3'b000;
        bif.s_ack = 1'b0;
        tick();
    endtask

    initial begin
        bif.m_req = '0; bif.m_we = '0; bif.m_addr = '0; bif.m_wdata = '0; bif.m_wstrb = '0;
        bif.s_ack = 1'b0; bif.s_rdata = '0;
        tif.m_req = '0; tif.m_we = '0; tif.m_addr = '0; tif.m_wdata = '0; tif.m_wstrb = '0;
        tif.s_ack = 1'b0; tif.s_rdata = '0;
        test_reset();
        test_round_robin();
        test_single_read();
        test_write();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule
